// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the IF/ID stall controller state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: NOP encoding, load-word opcode, and the stall FSM state enum.
package pipeline_pkg;

  // All-zero word decodes as a NOP in this pipeline.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Load-word major opcode, used by the hazard detector and test stimulus.
  localparam logic [5:0] OPCODE_LW = 6'b100011;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    RELEASE = 2'd2
  } stall_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// Latency: count reflects an inc one clock after it is sampled.
// Backpressure: none; inc is sampled every cycle.
//
// Ports: clock, reset_n (async active-low), inc (count enable), count (CNT_W value).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] FULL = {CNT_W{1'b1}};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != FULL)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/if_id_stall_ctrl.sv
// IF/ID register owner: turns load-use stall requests into a bounded freeze plus ID/EX bubble, applies flushes.
// Latency: freeze/bubble/pc_write_en are combinational (same cycle); IF/ID register updates on the next edge.
// Backpressure: a freeze holds PC and IF/ID for exactly STALL_CYCLES cycles; flush_req always overrides a freeze.
//
// Ports:
//   clock, reset_n                 clock and async active-low reset
//   stall_req, flush_req           hazard request (same-cycle) and taken branch/jump squash
//   instruction_f, pc_plus4_f      fetch stage inputs
//   instruction_d, pc_plus4_d      IF/ID register contents
//   pc_write_en, id_ex_bubble      PC update enable, NOP insertion into ID/EX
//   stall_active                   freeze in progress
//   stall_cycles_o, flush_cycles_o saturating perf counters (present only when STALL_PERF_CNT_EN is defined)
// Optional feature macro: STALL_PERF_CNT_EN
module if_id_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall_req,
  input  logic             flush_req,
  input  logic [31:0]      instruction_f,
  input  logic [31:0]      pc_plus4_f,
  output logic [31:0]      instruction_d,
  output logic [31:0]      pc_plus4_d,
  output logic             pc_write_en,
  output logic             id_ex_bubble,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_cycles_o
);

  // Down-counter reload: the accepting RUN cycle is the first frozen cycle.
  localparam logic [2:0] CNT_LOAD = 3'(STALL_CYCLES - 1);

  stall_state_t state;
  logic [2:0]   cnt;
  logic         freeze;

  // RELEASE never freezes, which guarantees one advancing cycle so the
  // detector cannot keep re-stalling on the instruction it is holding.
  always_comb begin
    freeze = 1'b0;
    if (!flush_req) begin
      freeze = (state == STALL) || ((state == RUN) && stall_req);
    end
  end

  // Reset forces the pipe quiet: no PC update and a bubble into ID/EX.
  assign pc_write_en  = reset_n & ~freeze;
  assign id_ex_bubble = ~reset_n | freeze;
  assign stall_active = reset_n & freeze;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RUN;
      cnt           <= 3'd0;
      instruction_d <= NOP_INSTR;
      pc_plus4_d    <= 32'h0;
    end else if (flush_req) begin
      // Flush wins in every state and cancels any freeze in progress.
      state         <= RUN;
      cnt           <= 3'd0;
      instruction_d <= NOP_INSTR;
      pc_plus4_d    <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (stall_req) begin
            cnt   <= CNT_LOAD;
            state <= (STALL_CYCLES == 1) ? RELEASE : STALL;
          end else begin
            instruction_d <= instruction_f;
            pc_plus4_d    <= pc_plus4_f;
          end
        end
        STALL: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= RELEASE;
          end
        end
        RELEASE: begin
          instruction_d <= instruction_f;
          pc_plus4_d    <= pc_plus4_f;
          state         <= RUN;
        end
        default: begin
          state <= RUN;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (freeze),
    .count   (stall_cycles_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (flush_req),
    .count   (flush_cycles_o)
  );
`else
  assign stall_cycles_o = '0;
  assign flush_cycles_o = '0;
`endif

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
module tb_if_id_stall_ctrl;

  localparam int CNT_W = 16;
  localparam int VW    = 32 + 32 + 3 + 2 * CNT_W;

  logic        clock;
  logic        reset_n;
  logic        stall_req;
  logic        flush_req;
  logic [31:0] instruction_f;
  logic [31:0] pc_plus4_f;

  logic [31:0]      ins_d [2];
  logic [31:0]      pc_d  [2];
  logic             pwe   [2];
  logic             bub   [2];
  logic             act   [2];
  logic [CNT_W-1:0] scnt  [2];
  logic [CNT_W-1:0] fcnt  [2];

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per DUT (index 0: 1-cycle stall, 1: 3-cycle stall).
  int          sc_of  [2] = '{1, 3};
  int          m_left [2];   // frozen cycles still owed by an accepted request
  bit          m_rel  [2];   // next cycle must advance regardless of stall_req
  logic [31:0] m_ins  [2];
  logic [31:0] m_pc   [2];
  int          m_sc   [2];
  int          m_fc   [2];

  if_id_stall_ctrl #(.STALL_CYCLES(1), .CNT_W(CNT_W)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .stall_req(stall_req), .flush_req(flush_req),
    .instruction_f(instruction_f), .pc_plus4_f(pc_plus4_f),
    .instruction_d(ins_d[0]), .pc_plus4_d(pc_d[0]), .pc_write_en(pwe[0]),
    .id_ex_bubble(bub[0]), .stall_active(act[0]),
    .stall_cycles_o(scnt[0]), .flush_cycles_o(fcnt[0])
  );

  if_id_stall_ctrl #(.STALL_CYCLES(3), .CNT_W(CNT_W)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .stall_req(stall_req), .flush_req(flush_req),
    .instruction_f(instruction_f), .pc_plus4_f(pc_plus4_f),
    .instruction_d(ins_d[1]), .pc_plus4_d(pc_d[1]), .pc_write_en(pwe[1]),
    .id_ex_bubble(bub[1]), .stall_active(act[1]),
    .stall_cycles_o(scnt[1]), .flush_cycles_o(fcnt[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [CNT_W-1:0] sat(int v);
`ifdef STALL_PERF_CNT_EN
    if (v >= (1 << CNT_W) - 1) return {CNT_W{1'b1}};
    return v[CNT_W-1:0];
`else
    return (v < 0) ? '1 : '0;
`endif
  endfunction

  function automatic bit model_frozen(int d);
    return !flush_req && (m_left[d] > 0 || (!m_rel[d] && stall_req));
  endfunction

  function automatic logic [VW-1:0] exp_vec(int d);
    bit f;
    f = model_frozen(d);
    return {m_ins[d], m_pc[d], !f, f, f, sat(m_sc[d]), sat(m_fc[d])};
  endfunction

  function automatic logic [VW-1:0] act_vec(int d);
    return {ins_d[d], pc_d[d], pwe[d], bub[d], act[d], scnt[d], fcnt[d]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_left[d] = 0; m_rel[d] = 0; m_ins[d] = 32'h0; m_pc[d] = 32'h0;
      m_sc[d] = 0; m_fc[d] = 0;
    end
  endtask

  task automatic model_step(int d);
    bit f;
    f = model_frozen(d);
    if (f) m_sc[d]++;
    if (flush_req) begin
      m_fc[d]++;
      m_left[d] = 0; m_rel[d] = 0; m_ins[d] = 32'h0; m_pc[d] = 32'h0;
    end else if (m_left[d] > 0) begin
      m_left[d]--;
      if (m_left[d] == 0) m_rel[d] = 1;
    end else if (m_rel[d]) begin
      m_rel[d] = 0; m_ins[d] = instruction_f; m_pc[d] = pc_plus4_f;
    end else if (stall_req) begin
      m_left[d] = sc_of[d] - 1;
      if (m_left[d] == 0) m_rel[d] = 1;
    end else begin
      m_ins[d] = instruction_f; m_pc[d] = pc_plus4_f;
    end
  endtask

  // One clock: model follows the edge, returns at the next falling edge.
  task automatic tick();
    @(posedge clock);
    if (reset_n) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; stall_req = 1'b0; flush_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall_req = 1'b0; flush_req = 1'b0;
    instruction_f = 32'h1234_5678; pc_plus4_f = 32'h4;
    model_reset();
    repeat (3) begin
      @(negedge clock);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({ins_d[d], pc_d[d], pwe[d], bub[d], scnt[d], fcnt[d]} !== {64'h0, 1'b0, 1'b1, {2*CNT_W{1'b0}}}) begin
          errors++;
          $display("FAIL reset dut%0d: got ins=%h pc=%h pwe=%b bub=%b sc=%0d fc=%0d, want all zero, pwe=0 bub=1",
                   d, ins_d[d], pc_d[d], pwe[d], bub[d], scnt[d], fcnt[d]);
        end
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_track();
    logic [31:0] prev;
    prev = 32'h0;
    for (int i = 0; i < 6; i++) begin
      instruction_f = $urandom; pc_plus4_f = pc_plus4_f + 32'd4;
      #1;
      checks++;
      if (pwe[0] !== 1'b1 || pwe[1] !== 1'b1 || ins_d[1] !== prev) begin
        errors++;
        $display("FAIL track cyc%0d: got pwe=%b%b ins_d=%h, want pwe=11 ins_d=%h", i, pwe[0], pwe[1], ins_d[1], prev);
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL track_vec dut%0d: got %h want %h", d, act_vec(d), exp_vec(d));
        end
      end
      prev = instruction_f;
      tick();
    end
  endtask

  task automatic test_single_stall();
    do_reset();
    instruction_f = {pipeline_pkg::OPCODE_LW, 26'h008_0004}; pc_plus4_f = 32'h104;
    tick();
    stall_req = 1'b1; instruction_f = 32'h012A_4020; pc_plus4_f = 32'h108;
    #1;
    checks++;
    if (pwe[0] !== 1'b0 || bub[0] !== 1'b1 || act[0] !== 1'b1 || ins_d[0] !== 32'h8C08_0004) begin
      errors++;
      $display("FAIL single_freeze: got pwe=%b bub=%b act=%b ins=%h, want 0 1 1 8c080004", pwe[0], bub[0], act[0], ins_d[0]);
    end
    tick();
    stall_req = 1'b0;
    #1;
    checks++;
    if (pwe[0] !== 1'b1 || bub[0] !== 1'b0 || ins_d[0] !== 32'h8C08_0004) begin
      errors++;
      $display("FAIL single_hold: got pwe=%b bub=%b ins=%h, want 1 0 8c080004", pwe[0], bub[0], ins_d[0]);
    end
    tick();
    #1;
    checks++;
    if (ins_d[0] !== 32'h012A_4020 || pc_d[0] !== 32'h108) begin
      errors++;
      $display("FAIL single_advance: got ins=%h pc=%h, want 012a4020 00000108", ins_d[0], pc_d[0]);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_vec(d) !== exp_vec(d)) begin
        errors++;
        $display("FAIL single_vec dut%0d: got %h want %h", d, act_vec(d), exp_vec(d));
      end
    end
  endtask

  task automatic test_held_stall();
    logic [7:0]       pat;
    logic [CNT_W-1:0] want_sc;
    pat = 8'h0;
    do_reset();
    stall_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instruction_f = $urandom; pc_plus4_f = pc_plus4_f + 32'd4;
      #1;
      pat = {pat[6:0], pwe[1]};
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL held_vec dut%0d cyc%0d: got %h want %h", d, i, act_vec(d), exp_vec(d));
        end
      end
      tick();
    end
    stall_req = 1'b0;
    #1;
    checks++;
    if (pat !== 8'b0001_0001) begin
      errors++;
      $display("FAIL held_pattern: got %b want 00010001", pat);
    end
`ifdef STALL_PERF_CNT_EN
    want_sc = 16'd6;
`else
    want_sc = 16'd0;
`endif
    checks++;
    if (scnt[1] !== want_sc) begin
      errors++;
      $display("FAIL held_stall_count: got %0d want %0d", scnt[1], want_sc);
    end
  endtask

  task automatic test_flush_and_stall();
    logic [CNT_W-1:0] want_fc;
    do_reset();
    instruction_f = 32'hDEAD_BEEF; pc_plus4_f = 32'h200;
    tick();
    stall_req = 1'b1; flush_req = 1'b1; instruction_f = 32'h1111_2222;
    #1;
    checks++;
    if (pwe[1] !== 1'b1 || bub[1] !== 1'b0 || act[1] !== 1'b0) begin
      errors++;
      $display("FAIL both_req_outputs: got pwe=%b bub=%b act=%b, want 1 0 0", pwe[1], bub[1], act[1]);
    end
    tick();
    stall_req = 1'b0; flush_req = 1'b0;
    #1;
`ifdef STALL_PERF_CNT_EN
    want_fc = 16'd1;
`else
    want_fc = 16'd0;
`endif
    checks++;
    if (ins_d[1] !== 32'h0 || pc_d[1] !== 32'h0 || fcnt[1] !== want_fc || scnt[1] !== 16'd0) begin
      errors++;
      $display("FAIL both_req_result: got ins=%h pc=%h fc=%0d sc=%0d, want 0 0 %0d 0", ins_d[1], pc_d[1], fcnt[1], scnt[1], want_fc);
    end
  endtask

  task automatic test_flush_mid_stall();
    do_reset();
    instruction_f = 32'hAAAA_0001; pc_plus4_f = 32'h300;
    tick();
    stall_req = 1'b1;
    #1;
    checks++;
    if (bub[1] !== 1'b1) begin
      errors++;
      $display("FAIL midflush_first_freeze: got bub=%b want 1", bub[1]);
    end
    tick();
    stall_req = 1'b0; flush_req = 1'b1;
    #1;
    checks++;
    if (pwe[1] !== 1'b1 || bub[1] !== 1'b0) begin
      errors++;
      $display("FAIL midflush_cancel: got pwe=%b bub=%b want 1 0", pwe[1], bub[1]);
    end
    tick();
    flush_req = 1'b0; instruction_f = 32'hBBBB_0002; pc_plus4_f = 32'h308;
    #1;
    checks++;
    if (ins_d[1] !== 32'h0 || pwe[1] !== 1'b1 || bub[1] !== 1'b0) begin
      errors++;
      $display("FAIL midflush_nop: got ins=%h pwe=%b bub=%b, want 0 1 0", ins_d[1], pwe[1], bub[1]);
    end
    tick();
    #1;
    checks++;
    if (ins_d[1] !== 32'hBBBB_0002) begin
      errors++;
      $display("FAIL midflush_run: got ins=%h want bbbb0002", ins_d[1]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    instruction_f = 32'hCCCC_0003; pc_plus4_f = 32'h400;
    tick();
    stall_req = 1'b1;
    tick();
    stall_req = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ins_d[0] !== 32'h0 || ins_d[1] !== 32'h0 || pwe[1] !== 1'b0 || bub[1] !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got ins=%h/%h pwe=%b bub=%b, want 0/0 0 1", ins_d[0], ins_d[1], pwe[1], bub[1]);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1; instruction_f = 32'hDDDD_0004; pc_plus4_f = 32'h500;
    #1;
    checks++;
    if (pwe[0] !== 1'b1 || pwe[1] !== 1'b1 || bub[1] !== 1'b0) begin
      errors++;
      $display("FAIL async_release: got pwe=%b%b bub=%b, want 11 0", pwe[0], pwe[1], bub[1]);
    end
    tick();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_vec(d) !== exp_vec(d)) begin
        errors++;
        $display("FAIL async_after dut%0d: got %h want %h", d, act_vec(d), exp_vec(d));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      stall_req     = ($urandom_range(99) < 35);
      flush_req     = ($urandom_range(99) < 10);
      instruction_f = $urandom;
      pc_plus4_f    = pc_plus4_f + 32'd4;
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d: got %h want %h", d, i, act_vec(d), exp_vec(d));
        end
      end
      tick();
    end
    stall_req = 1'b0; flush_req = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; stall_req = 1'b0; flush_req = 1'b0;
    instruction_f = 32'h0; pc_plus4_f = 32'h0;
    test_reset();
    test_track();
    test_single_stall();
    test_held_stall();
    test_flush_and_stall();
    test_flush_mid_stall();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
